mux_4x1_rr_arbiter: RTL
=======================

// Module: mux_4x1_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one N-bit 4:1 data mux among four requesters.
//  Each requester raises req[i] and holds it for as long as it needs the path.
//  The block registers a one-hot grant and the matching 2-bit mux select, then
//  steers the granted requester's word onto f with a qualifying valid.
//  Sits between four producers and a single shared downstream consumer.
// PARAMETERS
//  N        4  data width of w0..w3 and f
//  MAX_HOLD 8  cycles a holder may keep the grant while others wait (ARB_HOLD_LIMIT_EN only); >=1
// PORTS
//  clk    in   1  rising-edge clock, the only clock
//  reset  in   1  synchronous, active-high reset
//  req    in   4  request per requester; bit i belongs to wi
//  w0..w3 in   N  requester data words
//  grant  out  4  registered one-hot grant; all zeros when idle
//  sel    out  2  registered mux select = index of the granted requester
//  f      out  N  w[sel] while valid=1, else 0 (combinational from sel/valid)
//  valid  out  1  registered; 1 when any grant bit is set
// BEHAVIOUR
//  - Reset (sync, high): grant=0, sel=0, valid=0, f=0, ptr=0, hold_cnt=0, state=IDLE.
//    Reset overrides everything on that edge, including a grant in progress.
//  - ptr (2b) = search start; after a grant to i, ptr=i+1 mod 4 (3 wraps to 0).
//  - Pick: first set req bit scanning ptr, ptr+1, ..., ptr+3 mod 4.
//  - FSM states:
//    IDLE:  req==0 -> stay.
//    IDLE:  req!=0 -> GRANT on next edge with grant=onehot(pick), sel=pick, valid=1.
//           Latency from req rise to grant is 1 cycle.
//    GRANT: req[sel]=1 -> keep grant (see hold limit).
//    GRANT: req[sel]=0 and other req pending -> switch to pick on the same edge.
//           Zero-bubble handover; valid stays 1.
//    GRANT: req[sel]=0 and req==0 -> IDLE; grant=0, valid=0, sel holds its value.
//  - ptr updates on every edge that loads a new grant.
//  - Simultaneous requests: resolved purely by ptr order; no fixed priority.
//  - A requester re-raising req right after release waits behind all others pending.
//  - hold_cnt ($clog2(MAX_HOLD)+1 bits): cleared on each new grant, else +1 per GRANT cycle.
//    Saturates at MAX_HOLD-1.
//  - grant is always one-hot or zero; sel changes only when grant changes.
// CONFIGURATION
//  ARB_HOLD_LIMIT_EN defined:
//    - In GRANT with hold_cnt==MAX_HOLD-1, req[sel]=1 and another req pending:
//      force handover to pick on that edge; new holder gets hold_cnt=0.
//    - If no other req is pending, keep the grant and hold hold_cnt saturated.
//  ARB_HOLD_LIMIT_EN undefined:
//    - The holder keeps the grant until it drops req (may starve others).
//    - hold_cnt logic is not built; MAX_HOLD is ignored.
// TESTING
//  1 reset=1 with req=4'b1111 for 2 cycles -> grant=0, sel=0, valid=0, f=0 throughout
//  2 idle, req=4'b0100, w2=4'hA -> next edge grant=4'b0100, sel=2, valid=1, f=4'hA; drop req -> next edge valid=0, f=0
//  3 after test 2 (ptr=3), req=4'b1011 held, each holder drops req after 1 cycle
//    -> grants in order 3,0,1 with no idle cycle between them; valid stays 1
//  4 holder 1 drops req while req=4'b0001 -> same edge grant=4'b0001, sel=0, valid stays 1 (zero bubble)
//  5 ARB_HOLD_LIMIT_EN, MAX_HOLD=8: req0 held forever, req2 raised at cycle 2
//    -> grant moves to 2 exactly 8 cycles after grant0 began; without the macro grant0 persists
//  6 reset=1 for one cycle mid-grant with req held -> grant=0 next edge; after release, regrant from ptr=0 one cycle later

Source files
------------

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter that shares one N-bit 4:1 mux among four requesters.
// Optional holder time limit is built when ARB_HOLD_LIMIT_EN is defined.
module mux_4x1_rr_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [3:0]   req,
   input  logic [N-1:0] w0,
   input  logic [N-1:0] w1,
   input  logic [N-1:0] w2,
   input  logic [N-1:0] w3,
   output logic [3:0]   grant,
   output logic [1:0]   sel,
   output logic [N-1:0] f,
   output logic         valid
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

   if (MAX_HOLD < 1) begin : g_bad_max_hold
      $error("MAX_HOLD must be at least 1");
   end

   state_t      state_q;
   logic [3:0]  grant_q;
   logic [1:0]  sel_q;
   logic        valid_q;
   logic [1:0]  ptr_q;
   logic [2:0]  pick_s;
   logic        force_s;
   logic        load_s;

`ifdef ARB_HOLD_LIMIT_EN
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);
   logic [HOLD_W-1:0] hold_cnt_q;
`endif

   // Returns {found, index} of the first set bit scanning p, p+1, p+2, p+3 (mod 4).
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Candidate selection excludes the current holder so a forced handover never re-picks it.
   always_comb begin
      pick_s  = rr_pick(req & ~grant_q, ptr_q);
`ifdef ARB_HOLD_LIMIT_EN
      force_s = (state_q == GRANT) && req[sel_q] && (hold_cnt_q == HOLD_LIM);
`else
      force_s = 1'b0;
`endif
      if (state_q == IDLE) begin
         load_s = pick_s[2];
      end else begin
         load_s = pick_s[2] && (!req[sel_q] || force_s);
      end
   end

   // Arbitration FSM with registered grant, select, valid and search pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= 4'b0000;
         sel_q      <= 2'd0;
         valid_q    <= 1'b0;
         ptr_q      <= 2'd0;
`ifdef ARB_HOLD_LIMIT_EN
         hold_cnt_q <= '0;
`endif
      end else if (load_s) begin
         state_q    <= GRANT;
         grant_q    <= 4'b0001 << pick_s[1:0];
         sel_q      <= pick_s[1:0];
         valid_q    <= 1'b1;
         ptr_q      <= pick_s[1:0] + 2'd1;
`ifdef ARB_HOLD_LIMIT_EN
         hold_cnt_q <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= IDLE;
            end
            GRANT: begin
               if (!req[sel_q]) begin
                  // sel keeps its last value so the mux input stays stable while idle.
                  state_q <= IDLE;
                  grant_q <= 4'b0000;
                  valid_q <= 1'b0;
               end else begin
`ifdef ARB_HOLD_LIMIT_EN
                  if (hold_cnt_q != HOLD_LIM) begin
                     hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                  end else begin
                     hold_cnt_q <= hold_cnt_q;
                  end
`endif
                  state_q <= GRANT;
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= 4'b0000;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Output data path; forced to zero whenever no grant is active.
   always_comb begin
      if (valid_q) begin
         case (sel_q)
            2'd0:    f = w0;
            2'd1:    f = w1;
            2'd2:    f = w2;
            2'd3:    f = w3;
            default: f = '0;
         endcase
      end else begin
         f = '0;
      end
   end

   assign grant = grant_q;
   assign sel   = sel_q;
   assign valid = valid_q;

endmodule
